acc_cpu_core: RTL and testbench



---
 rtl/acc_cpu_core.sv | 127 ++++++++++++
 tb/tb_acc_cpu_core.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multicycle two-word accumulator CPU with req/ready memory port.
// Define ACC_CPU_ILLEGAL_TRAP_EN to trap opcodes 0/D/E into HALT with a sticky illegal flag.
module acc_cpu_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] ac_o,
  output logic                  halted,
  output logic                  illegal
);
  typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, EXEC, EXEC2, HALT} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, ir1_q, ir1_d, mbr_q, mbr_d;
  logic [DATA_WIDTH-1:0] ac_q, ac_d;
  logic [3:0] op_q, op_d;
  logic [1:0] cond_q, cond_d;
  logic fetch, exec_acc, req, we, done, skip;
  function automatic logic [DATA_WIDTH-1:0] alu(input logic [3:0] mode, input logic [DATA_WIDTH-1:0] a, b);
    return mode == 4'h3 ? a + b : mode == 4'h4 ? a - b : mode == 4'h5 ? a & b : mode == 4'h6 ? a | b : b;
  endfunction
  assign fetch    = state_q == FETCH0 || state_q == FETCH1;
  assign exec_acc = op_q inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hB, 4'hC};
  assign we       = state_q == EXEC && (op_q == 4'h2 || op_q == 4'hC);
  assign req      = fetch || state_q == EXEC2 || (state_q == EXEC && exec_acc);
  assign done     = !req || mem_ready;
  // Gating with reset keeps a write that coincides with reset from completing.
  assign mem_req   = req && !reset;
  assign mem_we    = req && we;
  assign mem_addr  = !req ? '0 : fetch ? pc_q : state_q == EXEC2 ? mbr_q : ir1_q;
  assign mem_wdata = !we ? '0 : op_q == 4'hC ? DATA_WIDTH'(pc_q) : ac_q;
  assign skip = cond_q == 2'b00 ? ac_q[DATA_WIDTH-1] :
                cond_q == 2'b01 ? ac_q == '0 :
                cond_q == 2'b10 ? !ac_q[DATA_WIDTH-1] && ac_q != '0 : 1'b0;
  assign pc_o   = pc_q;
  assign ac_o   = ac_q;
  assign halted = state_q == HALT;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ac_d    = ac_q;
    op_d    = op_q;
    cond_d  = cond_q;
    ir1_d   = ir1_q;
    mbr_d   = mbr_q;
    case (state_q)
      IDLE: state_d = run ? FETCH0 : IDLE;
      FETCH0: if (mem_ready) begin
        op_d    = mem_rdata[DATA_WIDTH-1 -: 4];
        cond_d  = mem_rdata[1:0];
        pc_d    = pc_q + 1'b1;
        state_d = FETCH1;
      end
      FETCH1: if (mem_ready) begin
        ir1_d   = mem_rdata[ADDR_WIDTH-1:0];
        pc_d    = pc_q + 1'b1;
        state_d = EXEC;
      end
      EXEC: if (done) begin
        state_d = run ? FETCH0 : IDLE;
        case (op_q)
          4'h1: ac_d = mem_rdata;
          4'h3, 4'h4, 4'h5, 4'h6: ac_d = alu(op_q, ac_q, mem_rdata);
          4'h7: state_d = HALT;
          4'h8: pc_d = skip ? pc_q + ADDR_WIDTH'(2) : pc_q;
          4'h9: pc_d = ir1_q;
          4'hA: ac_d = '0;
          4'hB: begin
            mbr_d   = mem_rdata[ADDR_WIDTH-1:0];
            state_d = EXEC2;
          end
          4'hC: pc_d = ir1_q + 1'b1;
          4'hF: ac_d = ~ac_q;
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
          4'h0, 4'hD, 4'hE: state_d = HALT;
`endif
          default: ;
        endcase
      end
      EXEC2: if (mem_ready) begin
        pc_d    = mem_rdata[ADDR_WIDTH-1:0];
        state_d = run ? FETCH0 : IDLE;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ac_q    <= '0;
      op_q    <= '0;
      cond_q  <= '0;
      ir1_q   <= '0;
      mbr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      op_q    <= op_d;
      cond_q  <= cond_d;
      ir1_q   <= ir1_d;
      mbr_q   <= mbr_d;
    end
  end
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
  logic ill_q;
  assign illegal = ill_q;
  always_ff @(posedge clk) begin
    if (reset) ill_q <= 1'b0;
    else if (state_q == EXEC && op_q inside {4'h0, 4'hD, 4'hE}) ill_q <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_acc_cpu_core.sv
// tb_acc_cpu_core: directed programs on an 8-bit core with wait-state memory plus a 4-bit-address core for PC wrap.
module tb_acc_cpu_core;
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, run = 1'b0, run_w = 1'b0;
  logic mem_req, mem_we, mem_ready, halted, illegal;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, pc_o, ac_o;
  logic mem_req_w, mem_we_w, halted_w, illegal_w;
  logic [3:0] mem_addr_w, pc_w;
  logic [7:0] mem_wdata_w, mem_rdata_w, ac_w;
  logic [7:0] mem [256];
  logic [7:0] mem_w [16];
  logic clr = 1'b0, pk_en = 1'b0, pk_w = 1'b0;
  logic [7:0] pk_a = '0, pk_d = '0;
  int wcnt = 0, nwait = 0, viol = 0, hreq = 0, n_chk = 0, n_pass = 0;
  logic prev_stall = 1'b0;
  logic [17:0] prev_bus = '0;

  always #5 clk = ~clk;

  acc_cpu_core #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_o(pc_o), .ac_o(ac_o), .halted(halted), .illegal(illegal));

  acc_cpu_core #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RESET_PC(4'hE)) dut_w (
    .clk(clk), .reset(reset), .run(run_w), .mem_req(mem_req_w), .mem_we(mem_we_w),
    .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w), .mem_rdata(mem_rdata_w), .mem_ready(1'b1),
    .pc_o(pc_w), .ac_o(ac_w), .halted(halted_w), .illegal(illegal_w));

  assign mem_rdata   = mem[mem_addr];
  assign mem_ready   = wcnt == nwait;
  assign mem_rdata_w = mem_w[mem_addr_w];

  always @(posedge clk) begin
    if (clr) mem <= '{default: 8'h00};
    else if (pk_en && !pk_w) mem[pk_a] <= pk_d;
    else if (mem_req && mem_we && mem_ready) mem[mem_addr] <= mem_wdata;
    if (pk_en && pk_w) mem_w[pk_a[3:0]] <= pk_d;
    wcnt <= (reset || !mem_req || mem_ready) ? 0 : wcnt + 1;
  end

  // Bus must not move while an access is stalled; no requests while halted.
  always @(negedge clk) begin
    if (!reset && prev_stall && {mem_req, mem_we, mem_addr, mem_wdata} != prev_bus) viol <= viol + 1;
    if (halted && mem_req) hreq <= hreq + 1;
    prev_stall <= mem_req && !mem_ready && !reset;
    prev_bus   <= {mem_req, mem_we, mem_addr, mem_wdata};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic poke(input logic w, input logic [7:0] a, input logic [7:0] d);
    pk_en = 1'b1; pk_w = w; pk_a = a; pk_d = d;
    @(posedge clk); #1 pk_en = 1'b0;
  endtask

  task automatic pw(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1);
    poke(1'b0, a, d0);
    poke(1'b0, a + 8'h01, d1);
  endtask

  task automatic clear_mem();
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  task automatic step(input int cyc);
    run = 1'b1;
    @(posedge clk); #1 run = 1'b0;
    repeat (cyc - 1) @(posedge clk);
    #1;
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    while (!halted && n < 300) begin
      @(posedge clk); #1 n++;
    end
  endtask

  task automatic load_sum_prog();
    clear_mem();
    pw(8'h00, 8'h10, 8'h20);
    pw(8'h02, 8'h30, 8'h21);
    pw(8'h04, 8'h20, 8'h22);
    pw(8'h06, 8'h70, 8'h00);
    pw(8'h20, 8'h05, 8'hFE);
  endtask

  initial begin
    int n;
    bit seen;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc_o), 'h00);
    chk("rst_ac", 32'(ac_o), 'h00);
    chk("rst_bus", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 'h0);
    chk("rst_flags", 32'({halted, illegal}), 'h0);
    chk("rst_pc_w", 32'(pc_w), 'hE);

    // Zero-wait sum program: 0x05 + 0xFE wraps to 0x03
    load_sum_prog();
    run = 1'b1; reset = 1'b0;
    wait_halt(n);
    chk("sum_cycles", 32'(n), 13);
    chk("sum_ac", 32'(ac_o), 'h03);
    chk("sum_mem22", 32'(mem[8'h22]), 'h03);
    chk("sum_pc", 32'(pc_o), 'h08);
    chk("sum_halted", 32'(halted), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("halt_pc_frozen", 32'(pc_o), 'h08);
    chk("halt_ac_frozen", 32'(ac_o), 'h03);

    // Same program with three wait states per access
    reset = 1'b1; run = 1'b0; nwait = 3;
    load_sum_prog();
    run = 1'b1; reset = 1'b0;
    wait_halt(n);
    chk("wait_cycles", 32'(n), 46);
    chk("wait_ac", 32'(ac_o), 'h03);
    chk("wait_mem22", 32'(mem[8'h22]), 'h03);
    chk("wait_pc", 32'(pc_o), 'h08);

    // Single-stepped program: skips, JNS/JUMPI, logic ops, opcode D
    reset = 1'b1; run = 1'b0; nwait = 0;
    clear_mem();
    pw(8'h00, 8'h10, 8'h30); pw(8'h02, 8'h80, 8'h00); pw(8'h06, 8'h82, 8'h00);
    pw(8'h08, 8'h83, 8'h00); pw(8'h0A, 8'hA0, 8'h00); pw(8'h0C, 8'h81, 8'h00);
    pw(8'h10, 8'hC0, 8'h40); pw(8'h12, 8'h12, 8'h31); pw(8'h14, 8'hF0, 8'h00);
    pw(8'h16, 8'h50, 8'h32); pw(8'h18, 8'h60, 8'h33); pw(8'h1A, 8'h40, 8'h34);
    pw(8'h1C, 8'hD0, 8'h00); pw(8'h1E, 8'h90, 8'h00); pw(8'h41, 8'hB0, 8'h40);
    pw(8'h30, 8'h80, 8'h0F); pw(8'h32, 8'h3C, 8'h05); poke(1'b0, 8'h34, 8'h36);
    reset = 1'b0;
    step(4); chk("ld_ac", 32'(ac_o), 'h80); chk("ld_pc", 32'(pc_o), 'h02);
    step(4); chk("skip_lt_taken", 32'(pc_o), 'h06);
    step(4); chk("skip_gt_not", 32'(pc_o), 'h08);
    step(4); chk("skip_never", 32'(pc_o), 'h0A);
    step(4); chk("clear_ac", 32'(ac_o), 'h00);
    step(4); chk("skip_eq_taken", 32'(pc_o), 'h10);
    step(4); chk("jns_mem", 32'(mem[8'h40]), 'h12); chk("jns_pc", 32'(pc_o), 'h41);
    step(5); chk("jumpi_pc", 32'(pc_o), 'h12);
    step(4); chk("ld2_ac", 32'(ac_o), 'h0F);
    step(4); chk("not_ac", 32'(ac_o), 'hF0);
    step(4); chk("and_ac", 32'(ac_o), 'h30);
    step(4); chk("or_ac", 32'(ac_o), 'h35);
    step(4); chk("sub_ac", 32'(ac_o), 'hFF);
    step(4);
    chk("opD_illegal", 32'(illegal), 32'(TRAP));
    chk("opD_halted", 32'(halted), 32'(TRAP));
    chk("opD_pc", 32'(pc_o), 'h1E);
    step(4);
    chk("after_opD_pc", 32'(pc_o), TRAP ? 'h1E : 'h00);
    chk("after_opD_req", 32'(mem_req), 0);

    // Reset lands on the completing edge of a stalled STORE
    reset = 1'b1; nwait = 3;
    pw(8'h00, 8'h10, 8'h30); pw(8'h02, 8'h20, 8'h50); poke(1'b0, 8'h50, 8'hAA);
    run = 1'b1; reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = mem_req && mem_we && mem_ready;
    end
    chk("st_reached", 32'(seen), 1);
    chk("st_pre_ac", 32'(ac_o), 'h80);
    chk("st_pre_pc", 32'(pc_o), 'h04);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("st_rst_req", 32'(mem_req), 0);
    chk("st_rst_mem", 32'(mem[8'h50]), 'hAA);
    chk("st_rst_pc", 32'(pc_o), 'h00);
    chk("st_rst_ac", 32'(ac_o), 'h00);
    run = 1'b0; nwait = 0;

    // 4-bit address core: instruction at 0xE wraps the next fetch to 0x0
    poke(1'b1, 8'h0E, 8'hA0); poke(1'b1, 8'h0F, 8'h00);
    poke(1'b1, 8'h00, 8'h70); poke(1'b1, 8'h01, 8'h00);
    run_w = 1'b1; reset = 1'b0;
    @(posedge clk); #1;
    chk("wrap_f0_addr", 32'(mem_addr_w), 'hE);
    repeat (2) @(posedge clk);
    #1;
    chk("wrap_pc", 32'(pc_w), 'h0);
    @(posedge clk); #1;
    chk("wrap_fetch", 32'({mem_req_w, mem_addr_w}), 'h10);
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_halted", 32'(halted_w), 1);
    chk("wrap_halt_pc", 32'(pc_w), 'h2);
    run_w = 1'b0;

    chk("bus_stable", 32'(viol), 0);
    chk("halt_no_req", 32'(hreq), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
